// File: rtl/sha2_msg_sched.sv
// SHA-2 message schedule generator: expands one 16-word padded block into
// ROUNDS schedule words W[t] through a sliding 16-word window, one word per handshake.
module sha2_msg_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*WORD_W-1:0]  blk_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_data,
  output logic [6:0]            w_idx,
  output logic                  w_last
);

  if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_params
    $error("sha2_msg_sched: WORD_W/ROUNDS must be 32/64 or 64/80");
  end

  // Rotation/shift amounts of the small sigma functions for the selected width
  localparam int S0_R1 = (WORD_W == 32) ? 7  : 1;
  localparam int S0_R2 = (WORD_W == 32) ? 18 : 8;
  localparam int S0_SH = (WORD_W == 32) ? 3  : 7;
  localparam int S1_R1 = (WORD_W == 32) ? 17 : 19;
  localparam int S1_R2 = (WORD_W == 32) ? 19 : 61;
  localparam int S1_SH = (WORD_W == 32) ? 10 : 6;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  logic [WORD_W-1:0]  win [16];
  logic [6:0]         t;
  logic [WORD_W-1:0]  next_word;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

  // win[0..15] holds W[t..t+15]; the new word W[t+16] enters at the top
  always_comb begin
    next_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= 7'd0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) win[i] <= blk_data[(16-i)*WORD_W-1 -: WORD_W];
            t     <= 7'd0;
            state <= RUN;
          end
        end
        RUN: begin
          // The final word only retires the block; the window is left untouched
          if (w_ready) begin
            if (t == LAST_T) begin
              state <= IDLE;
            end else begin
              for (int i = 0; i < 15; i++) win[i] <= win[i+1];
              win[15] <= next_word;
              t       <= t + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blk_ready = (state == IDLE);
  assign w_valid   = (state == RUN);
  assign w_data    = w_valid ? win[0] : '0;
  assign w_idx     = w_valid ? t : 7'd0;
  assign w_last    = w_valid && (t == LAST_T);

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Self-checking bench for sha2_msg_sched: 32- and 64-bit instances driven with
// known and random blocks, compared against a FIPS-style recurrence model.
module tb_sha2_msg_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         b32_valid, b32_ready, w32_valid, w32_ready, w32_last;
  logic [511:0] b32_data;
  logic [31:0]  w32_data;
  logic [6:0]   w32_idx;
  logic          b64_valid, b64_ready, w64_valid, w64_ready, w64_last;
  logic [1023:0] b64_data;
  logic [63:0]   w64_data;
  logic [6:0]    w64_idx;

  sha2_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .blk_valid(b32_valid), .blk_ready(b32_ready), .blk_data(b32_data),
    .w_valid(w32_valid), .w_ready(w32_ready), .w_data(w32_data), .w_idx(w32_idx), .w_last(w32_last));

  sha2_msg_sched #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .blk_valid(b64_valid), .blk_ready(b64_ready), .blk_data(b64_data),
    .w_valid(w64_valid), .w_ready(w64_ready), .w_data(w64_data), .w_idx(w64_idx), .w_last(w64_last));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          sel64 = 1'b0;
  logic        m_wvalid, m_wlast, m_bready;
  logic [63:0] m_wdata;
  logic [6:0]  m_widx;
  assign m_wvalid = sel64 ? w64_valid : w32_valid;
  assign m_wlast  = sel64 ? w64_last  : w32_last;
  assign m_bready = sel64 ? b64_ready : b32_ready;
  assign m_wdata  = sel64 ? w64_data  : {32'h0, w32_data};
  assign m_widx   = sel64 ? w64_idx   : w32_idx;

  logic [63:0] exp_w [80];
  logic [63:0] obs_data [$];
  int          obs_idx [$];
  bit          obs_last [$];
  int          stall_bad, stall_cycles, first_hs_cyc, last_hs_cyc;
  bit          lat_ok, post_ok, timed_out;

  function automatic logic [31:0] ms0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ms1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic logic [63:0] ms0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] ms1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  // Reference: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], carries dropped
  function automatic void gen_sched(input bit wide, input logic [1023:0] blk);
    logic [31:0] w32 [64];
    logic [63:0] w64 [80];
    longint unsigned acc;
    if (wide) begin
      for (int i = 0; i < 16; i++) w64[i] = blk[1023-64*i -: 64];
      for (int k = 16; k < 80; k++) w64[k] = ms1_64(w64[k-2]) + w64[k-7] + ms0_64(w64[k-15]) + w64[k-16];
      for (int k = 0; k < 80; k++) exp_w[k] = w64[k];
    end else begin
      for (int i = 0; i < 16; i++) w32[i] = blk[511-32*i -: 32];
      for (int k = 16; k < 64; k++) begin
        acc = 64'(ms1_32(w32[k-2])) + 64'(w32[k-7]) + 64'(ms0_32(w32[k-15])) + 64'(w32[k-16]);
        w32[k] = acc[31:0];
      end
      for (int k = 0; k < 64; k++) exp_w[k] = {32'h0, w32[k]};
      for (int k = 64; k < 80; k++) exp_w[k] = 64'h0;
    end
  endfunction

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1023:0] abc_blk(input bit wide);
    logic [1023:0] b;
    b = '0;
    if (wide) begin
      b[1023:960] = 64'h6162638000000000;
      b[63:0]     = 64'h18;
    end else begin
      b[511:480] = 32'h61626380;
      b[31:0]    = 32'h18;
    end
    return b;
  endfunction

  task automatic set_blk(input bit v, input logic [1023:0] d);
    if (sel64) begin b64_valid = v; b64_data = d; end
    else begin b32_valid = v; b32_data = d[511:0]; end
  endtask

  task automatic set_wready(input bit r);
    if (sel64) w64_ready = r; else w32_ready = r;
  endtask

  // Offers one block, then consumes words with w_ready high duty% of cycles
  task automatic run_block(input logic [1023:0] blk, input int duty, input bit hold);
    bit stalled, done, rdy;
    logic [63:0] sd;
    logic [6:0] si;
    logic sl;
    int n;
    obs_data.delete(); obs_idx.delete(); obs_last.delete();
    stall_bad = 0; stall_cycles = 0; first_hs_cyc = -1;
    lat_ok = 1'b0; post_ok = 1'b0; timed_out = 1'b0;
    set_blk(1'b1, blk);
    n = 0;
    while (m_bready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (m_bready !== 1'b1) begin timed_out = 1'b1; set_blk(1'b0, blk); return; end
    @(negedge clk);
    if (!hold) set_blk(1'b0, blk);
    lat_ok = (m_wvalid === 1'b1) && (m_widx === 7'd0) && (m_bready === 1'b0);
    stalled = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 2000) begin
      if (stalled && (m_wdata !== sd || m_widx !== si || m_wlast !== sl || m_wvalid !== 1'b1)) stall_bad++;
      rdy = ($urandom_range(99) < duty);
      set_wready(rdy);
      if (hold) set_blk(1'b1, rand_blk());
      if (m_wvalid && rdy) begin
        obs_data.push_back(m_wdata);
        obs_idx.push_back(int'(m_widx));
        obs_last.push_back(m_wlast);
        if (first_hs_cyc < 0) first_hs_cyc = cyc + 1;
        if (m_wlast) begin last_hs_cyc = cyc + 1; done = 1'b1; end
        stalled = 1'b0;
      end else if (m_wvalid) begin
        stalled = 1'b1; sd = m_wdata; si = m_widx; sl = m_wlast; stall_cycles++;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    timed_out = !done;
    post_ok = (m_wvalid === 1'b0) && (m_bready === 1'b1);
    if (!hold) set_wready(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b32_valid = 1'b0; b32_data = '0; w32_ready = 1'b0;
    b64_valid = 1'b0; b64_data = '0; w64_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({w32_valid, w32_last, w32_data, w32_idx} !== '0) begin
      failures++; $display("FAIL reset_out32: got v=%0b l=%0b d=%h i=%0d want all 0", w32_valid, w32_last, w32_data, w32_idx);
    end
    checks++;
    if ({w64_valid, w64_last, w64_data, w64_idx} !== '0) begin
      failures++; $display("FAIL reset_out64: got v=%0b l=%0b d=%h i=%0d want all 0", w64_valid, w64_last, w64_data, w64_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b32_ready !== 1'b1 || b64_ready !== 1'b1 || w32_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release: got rdy32=%0b rdy64=%0b wv32=%0b want 1 1 0", b32_ready, b64_ready, w32_valid);
    end
  endtask

  task automatic test_abc(input bit wide);
    int nw;
    logic [63:0] w16, w17;
    sel64 = wide;
    nw = wide ? 80 : 64;
    w16 = wide ? 64'h6162638000000000 : 64'h61626380;
    w17 = wide ? 64'h00030000000000C0 : 64'h000F0000;
    gen_sched(wide, abc_blk(wide));
    run_block(abc_blk(wide), 100, 1'b0);
    checks++;
    if (timed_out || obs_data.size() != nw) begin
      failures++; $display("FAIL abc%0d_count: got %0d words timeout=%0b want %0d", wide ? 64 : 32, obs_data.size(), timed_out, nw);
    end
    checks++;
    if (!lat_ok || !post_ok) begin
      failures++; $display("FAIL abc%0d_handshake: got lat_ok=%0b post_ok=%0b want 1 1", wide ? 64 : 32, lat_ok, post_ok);
    end
    for (int k = 0; k < obs_data.size() && k < nw; k++) begin
      checks++;
      if (obs_data[k] !== exp_w[k] || obs_idx[k] != k || obs_last[k] != (k == nw - 1)) begin
        failures++;
        $display("FAIL abc%0d_word[%0d]: got d=%h i=%0d l=%0b want d=%h i=%0d l=%0b",
                 wide ? 64 : 32, k, obs_data[k], obs_idx[k], obs_last[k], exp_w[k], k, k == nw - 1);
      end
    end
    checks++;
    if (obs_data.size() < 18 || obs_data[16] !== w16 || obs_data[17] !== w17) begin
      failures++; $display("FAIL abc%0d_w16_w17: got size=%0d want W16=%h W17=%h", wide ? 64 : 32, obs_data.size(), w16, w17);
    end
  endtask

  task automatic test_stall();
    sel64 = 1'b0;
    gen_sched(1'b0, abc_blk(1'b0));
    run_block(abc_blk(1'b0), 50, 1'b0);
    checks++;
    if (timed_out || obs_data.size() != 64 || stall_cycles == 0) begin
      failures++; $display("FAIL stall_count: got %0d words stalls=%0d timeout=%0b want 64 >0 0", obs_data.size(), stall_cycles, timed_out);
    end
    checks++;
    if (stall_bad != 0) begin
      failures++; $display("FAIL stall_hold: got %0d unstable stall cycles want 0", stall_bad);
    end
    for (int k = 0; k < obs_data.size() && k < 64; k++) begin
      checks++;
      if (obs_data[k] !== exp_w[k] || obs_idx[k] != k) begin
        failures++; $display("FAIL stall_word[%0d]: got d=%h i=%0d want d=%h i=%0d", k, obs_data[k], obs_idx[k], exp_w[k], k);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] ba, bb;
    int last_a;
    sel64 = 1'b0;
    ba = rand_blk(); bb = rand_blk();
    for (int blk_n = 0; blk_n < 2; blk_n++) begin
      gen_sched(1'b0, blk_n == 0 ? ba : bb);
      run_block(blk_n == 0 ? ba : bb, 100, blk_n == 0);
      if (blk_n == 0) begin
        last_a = last_hs_cyc;
      end else begin
        checks++;
        if (first_hs_cyc != last_a + 2) begin
          failures++; $display("FAIL b2b_gap: got W0 at +%0d cycles want +2", first_hs_cyc - last_a);
        end
      end
      checks++;
      if (timed_out || obs_data.size() != 64) begin
        failures++; $display("FAIL b2b_count[%0d]: got %0d words want 64", blk_n, obs_data.size());
      end
      for (int k = 0; k < obs_data.size() && k < 64; k++) begin
        checks++;
        if (obs_data[k] !== exp_w[k]) begin
          failures++; $display("FAIL b2b_word[%0d][%0d]: got %h want %h", blk_n, k, obs_data[k], exp_w[k]);
        end
      end
    end
    w32_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    sel64 = 1'b0;
    set_blk(1'b1, rand_blk());
    @(negedge clk);
    set_blk(1'b0, '0);
    set_wready(1'b1);
    n = 0;
    while (!(w32_valid === 1'b1 && w32_idx === 7'd20) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (w32_idx !== 7'd20) begin
      failures++; $display("FAIL rstmid_reach: got idx=%0d want 20", w32_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({w32_valid, w32_last, w32_data, w32_idx} !== '0) begin
      failures++; $display("FAIL rstmid_during: got v=%0b l=%0b d=%h i=%0d want all 0", w32_valid, w32_last, w32_data, w32_idx);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (w32_valid !== 1'b0) begin
        failures++; $display("FAIL rstmid_after[%0d]: got w_valid=%0b want 0", k, w32_valid);
      end
    end
    gen_sched(1'b0, abc_blk(1'b0));
    run_block(abc_blk(1'b0), 100, 1'b0);
    checks++;
    if (obs_data.size() != 64 || obs_data[0] !== 64'h61626380 || obs_idx[0] != 0) begin
      failures++; $display("FAIL rstmid_restart: got %0d words want 64 starting W0=61626380 idx 0", obs_data.size());
    end
    for (int k = 0; k < obs_data.size() && k < 64; k++) begin
      checks++;
      if (obs_data[k] !== exp_w[k] || obs_idx[k] != k) begin
        failures++; $display("FAIL rstmid_word[%0d]: got d=%h i=%0d want d=%h i=%0d", k, obs_data[k], obs_idx[k], exp_w[k], k);
      end
    end
  endtask

  task automatic test_random_blocks(input bit wide, input bit all_ones, input int count);
    logic [1023:0] b;
    int nw;
    sel64 = wide;
    nw = wide ? 80 : 64;
    for (int r = 0; r < count; r++) begin
      b = all_ones ? {1024{1'b1}} : rand_blk();
      gen_sched(wide, b);
      run_block(b, all_ones ? 100 : 70, 1'b0);
      checks++;
      if (timed_out || obs_data.size() != nw || stall_bad != 0) begin
        failures++; $display("FAIL rand%0d_blk[%0d]: got %0d words bad_stalls=%0d want %0d 0", wide ? 64 : 32, r, obs_data.size(), stall_bad, nw);
      end
      for (int k = 0; k < obs_data.size() && k < nw; k++) begin
        checks++;
        if (obs_data[k] !== exp_w[k] || obs_idx[k] != k || obs_last[k] != (k == nw - 1)) begin
          failures++;
          $display("FAIL rand%0d_word[%0d][%0d]: got d=%h i=%0d want d=%h i=%0d", wide ? 64 : 32, r, k, obs_data[k], obs_idx[k], exp_w[k], k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc(1'b0);
    test_abc(1'b1);
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random_blocks(1'b0, 1'b1, 1);
    test_random_blocks(1'b0, 1'b0, 3);
    test_random_blocks(1'b1, 1'b0, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
